// File: rtl/ir_field_stage_if.sv
// ir_field_stage_if: fetch->decode bus; upstream push (in_*), downstream pop (out_*), decoded fields, flush and drop counter
interface ir_field_stage_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic [15:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] instr_out;
  logic [15:0] pc_out;
  logic [3:0]  opcode;
  logic [2:0]  dest;
  logic [2:0]  src1;
  logic [2:0]  src2;
  logic        imm_flag;
  logic        jsr_flag;
  logic [1:0]  shift_ctl;
  logic [5:0]  offset6;
  logic [8:0]  offset9;
  logic [4:0]  imm5;
  logic [3:0]  imm4;
  logic [10:0] offset11;
  logic [7:0]  trap8;
  logic [7:0]  drop_count;
  modport master (
    output flush, in_valid, instr, pc, out_ready,
    input  in_ready, out_valid, instr_out, pc_out, opcode, dest, src1, src2, imm_flag, jsr_flag,
           shift_ctl, offset6, offset9, imm5, imm4, offset11, trap8, drop_count
  );
  modport slave (
    input  flush, in_valid, instr, pc, out_ready,
    output in_ready, out_valid, instr_out, pc_out, opcode, dest, src1, src2, imm_flag, jsr_flag,
           shift_ctl, offset6, offset9, imm5, imm4, offset11, trap8, drop_count
  );
endinterface

// File: rtl/ir_field_stage.sv
// ir_field_stage: 2-entry {instr,pc} FIFO with decoded head fields; ports clk, reset, bus (slave: push in_*, pop out_*, flush, drop_count)
module ir_field_stage (
  input logic          clk,
  input logic          reset,
  ir_field_stage_if.slave bus
);
  logic [31:0] mem [2];
  logic        head;
  logic        tail;
  logic [1:0]  count;
  logic [7:0]  drop;
  logic        push;
  logic        pop;
  logic [9:0]  dsum;
  logic [31:0] hd;
  always_comb begin
    bus.in_ready  = count < 2'd2;
    bus.out_valid = count != 2'd0;
    push          = bus.in_valid && bus.in_ready;
    pop           = bus.out_valid && bus.out_ready;
    dsum          = 10'(drop) + 10'(count) + 10'(push);
    hd            = bus.out_valid ? mem[head] : 32'h0;
    bus.instr_out  = hd[31:16];
    bus.pc_out     = hd[15:0];
    bus.opcode     = bus.instr_out[15:12];
    bus.dest       = bus.instr_out[11:9];
    bus.src1       = bus.instr_out[8:6];
    bus.src2       = bus.instr_out[2:0];
    bus.imm_flag   = bus.instr_out[5];
    bus.jsr_flag   = bus.instr_out[11];
    bus.shift_ctl  = bus.instr_out[5:4];
    bus.offset6    = bus.instr_out[5:0];
    bus.offset9    = bus.instr_out[8:0];
    bus.imm5       = bus.instr_out[4:0];
    bus.imm4       = bus.instr_out[3:0];
    bus.offset11   = bus.instr_out[10:0];
    bus.trap8      = bus.instr_out[7:0];
    bus.drop_count = drop;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
      drop  <= 8'd0;
    end else if (bus.flush) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
      drop  <= dsum > 10'd255 ? 8'hFF : dsum[7:0];
    end else begin
      count <= count + 2'(push) - 2'(pop);
      head  <= head ^ pop;
      tail  <= tail ^ push;
    end
  end
  always_ff @(posedge clk)
    if (!reset && !bus.flush && push) mem[tail] <= {bus.instr, bus.pc};
endmodule

// File: tb/tb_ir_field_stage.sv
// tb_ir_field_stage: directed and random checks of ir_field_stage against a queue model
module tb_ir_field_stage;
  logic clk = 1'b0;
  logic reset;
  int vectors = 0;
  int errs = 0;
  logic [31:0] q[$];
  int mdrop = 0;
  ir_field_stage_if bus();
  ir_field_stage dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_model();
    int ei;
    int ep;
    ei = q.size() != 0 ? int'(q[0][31:16]) : 0;
    ep = q.size() != 0 ? int'(q[0][15:0]) : 0;
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    chk("instr_out", 32'(bus.instr_out), 32'(ei));
    chk("pc_out", 32'(bus.pc_out), 32'(ep));
    chk("opcode", 32'(bus.opcode), 32'(ei / 4096));
    chk("dest", 32'(bus.dest), 32'((ei / 512) % 8));
    chk("src1", 32'(bus.src1), 32'((ei / 64) % 8));
    chk("src2", 32'(bus.src2), 32'(ei % 8));
    chk("imm_flag", 32'(bus.imm_flag), 32'((ei / 32) % 2));
    chk("jsr_flag", 32'(bus.jsr_flag), 32'((ei / 2048) % 2));
    chk("shift_ctl", 32'(bus.shift_ctl), 32'((ei / 16) % 4));
    chk("offset6", 32'(bus.offset6), 32'(ei % 64));
    chk("offset9", 32'(bus.offset9), 32'(ei % 512));
    chk("imm5", 32'(bus.imm5), 32'(ei % 32));
    chk("imm4", 32'(bus.imm4), 32'(ei % 16));
    chk("offset11", 32'(bus.offset11), 32'(ei % 2048));
    chk("trap8", 32'(bus.trap8), 32'(ei % 256));
    chk("drop_count", 32'(bus.drop_count), 32'(mdrop));
  endtask
  task automatic step(input logic r, input logic fl, input logic iv, input logic [15:0] ins,
                      input logic [15:0] p, input logic ordy);
    int sz;
    @(negedge clk);
    reset = r;
    bus.flush = fl;
    bus.in_valid = iv;
    bus.instr = ins;
    bus.pc = p;
    bus.out_ready = ordy;
    check_model();
    sz = q.size();
    if (r) begin
      q = {};
      mdrop = 0;
    end else if (fl) begin
      mdrop = mdrop + sz + ((iv && sz < 2) ? 1 : 0);
      if (mdrop > 255) mdrop = 255;
      q = {};
    end else begin
      if (sz != 0 && ordy) void'(q.pop_front());
      if (iv && sz < 2) q.push_back({ins, p});
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.instr = 16'h0;
    bus.pc = 16'h0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(0, 0, 0, 16'h0, 16'h0, 0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    step(0, 0, 1, 16'h1262, 16'h3002, 1);
    chk("p30_valid", 32'(bus.out_valid), 32'd1);
    chk("p30_opcode", 32'(bus.opcode), 32'h1);
    chk("p30_dest", 32'(bus.dest), 32'd1);
    chk("p30_src1", 32'(bus.src1), 32'd1);
    chk("p30_imm_flag", 32'(bus.imm_flag), 32'd1);
    chk("p30_imm5", 32'(bus.imm5), 32'h02);
    chk("p30_pc", 32'(bus.pc_out), 32'h3002);
    step(0, 0, 0, 16'h0, 16'h0, 1);
    chk("p30_empty", 32'(bus.out_valid), 32'd0);
    step(0, 0, 1, 16'h0FFF, 16'h3004, 0);
    step(0, 0, 1, 16'hF025, 16'h3006, 0);
    chk("p31_in_ready", 32'(bus.in_ready), 32'd0);
    step(0, 0, 1, 16'h1111, 16'h3008, 0);
    chk("p31_stall_offset9", 32'(bus.offset9), 32'h1FF);
    step(0, 0, 0, 16'h0, 16'h0, 1);
    chk("p31_opcode", 32'(bus.opcode), 32'hF);
    chk("p31_trap8", 32'(bus.trap8), 32'h25);
    step(0, 0, 1, 16'h2222, 16'h300A, 0);
    step(1, 0, 0, 16'h0, 16'h0, 0);
    chk("p34_valid", 32'(bus.out_valid), 32'd0);
    chk("p34_in_ready", 32'(bus.in_ready), 32'd1);
    chk("p34_drop", 32'(bus.drop_count), 32'd0);
    step(0, 0, 1, 16'h3333, 16'h4000, 0);
    step(0, 0, 1, 16'h4444, 16'h4002, 0);
    step(0, 0, 1, 16'h5555, 16'h4004, 1);
    chk("p32_in_ready", 32'(bus.in_ready), 32'd1);
    chk("p32_head", 32'(bus.instr_out), 32'h4444);
    step(0, 0, 1, 16'h6666, 16'h4006, 0);
    step(0, 1, 1, 16'h7777, 16'h4008, 0);
    chk("p33_valid", 32'(bus.out_valid), 32'd0);
    chk("p33_drop", 32'(bus.drop_count), 32'd2);
    for (int i = 0; i < 140; i++) begin
      step(0, 0, 1, 16'(i), 16'(i * 2), 0);
      step(0, 0, 1, 16'(i + 1), 16'(i * 2 + 2), 0);
      step(0, 1, 1, 16'h0, 16'h0, 0);
    end
    chk("p33_sat", 32'(bus.drop_count), 32'hFF);
    step(1, 0, 0, 16'h0, 16'h0, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0, 1'($urandom),
           16'($urandom), 16'($urandom), $urandom_range(0, 3) != 0);
    step(0, 0, 0, 16'h0, 16'h0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
